// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bundle of the register file: two read ports, one write port, reservations and busy flags.
// The slave modport belongs to the register file; the master modport belongs to the pipeline stages.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] rd_addr1;
    logic [ADDR_WIDTH-1:0] rd_addr2;
    logic [DATA_WIDTH-1:0] rd_data1;
    logic [DATA_WIDTH-1:0] rd_data2;
    logic                  rd_busy1;
    logic                  rd_busy2;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rsv_en;
    logic [ADDR_WIDTH-1:0] rsv_addr;
    logic                  flush;
    logic [NUM_REGS-1:0]   busy_vec;

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_vec
    );

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with combinational reads, one synchronous write port, optional bypass/R0 and a busy scoreboard.
// Reads are zero-latency, writes and busy updates land on the next edge; there is no backpressure.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    logic                  wr_eff;
    logic                  rsv_eff;
    logic [DATA_WIDTH-1:0] rd_data1;
    logic [DATA_WIDTH-1:0] rd_data2;
    logic                  rd_busy1;
    logic                  rd_busy2;

    // With a hardwired R0, writes and reservations to address 0 simply vanish.
    assign wr_eff  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == ADDR_ZERO));
    assign rsv_eff = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == ADDR_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (wr_eff) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Reservation beats flush beats writeback: a new producer is always younger than the one retiring.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rsv_eff && (bus.rsv_addr == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b1;
            end else if (bus.flush) begin
                busy_d[i] = 1'b0;
            end else if (wr_eff && (bus.wr_addr == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data1 = regs_q[bus.rd_addr1];
        rd_busy1 = busy_q[bus.rd_addr1];
        if ((BYPASS != 0) && wr_eff && (bus.wr_addr == bus.rd_addr1)) begin
            rd_data1 = bus.wr_data;
            rd_busy1 = 1'b0;
        end
        // Holding reset masks the bypass path too, so reads show the cleared file.
        if (reset || ((ZERO_REG != 0) && (bus.rd_addr1 == ADDR_ZERO))) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end
    end

    always_comb begin
        rd_data2 = regs_q[bus.rd_addr2];
        rd_busy2 = busy_q[bus.rd_addr2];
        if ((BYPASS != 0) && wr_eff && (bus.wr_addr == bus.rd_addr2)) begin
            rd_data2 = bus.wr_data;
            rd_busy2 = 1'b0;
        end
        if (reset || ((ZERO_REG != 0) && (bus.rd_addr2 == ADDR_ZERO))) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end
    end

    assign bus.rd_data1 = rd_data1;
    assign bus.rd_data2 = rd_data2;
    assign bus.rd_busy1 = rd_busy1;
    assign bus.rd_busy2 = rd_busy2;
    assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default 16x16 file with bypass and zero R0, plus a 32x32 file without bypass or zero R0.
module tb_regfile_scoreboard;
    logic clk;
    logic reset;

    regfile_scoreboard_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) a ();
    regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b ();

    regfile_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a)
    );

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a.wr_en = 1'b0; a.wr_addr = '0; a.wr_data = '0;
        a.rsv_en = 1'b0; a.rsv_addr = '0; a.flush = 1'b0;
        b.wr_en = 1'b0; b.wr_addr = '0; b.wr_data = '0;
        b.rsv_en = 1'b0; b.rsv_addr = '0; b.flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        a.rd_addr1 = '0; a.rd_addr2 = '0;
        b.rd_addr1 = '0; b.rd_addr2 = '0;
        #3;
        chk("rst_busy_a", 64'(a.busy_vec), 64'h0);
        chk("rst_rd1_a",  64'(a.rd_data1), 64'h0);
        chk("rst_busy_b", 64'(b.busy_vec), 64'h0);
        #9 reset = 1'b0;
        step();

        // Write R3 and reserve R8, then reset asynchronously in the middle of another write.
        a.wr_en = 1'b1; a.wr_addr = 4'd3; a.wr_data = 16'h1234;
        a.rsv_en = 1'b1; a.rsv_addr = 4'd8;
        step();
        idle();
        a.rd_addr1 = 4'd3;
        #1;
        chk("r3_written", 64'(a.rd_data1), 64'h1234);
        chk("r8_busy",    64'(a.busy_vec), 64'h0100);
        a.wr_en = 1'b1; a.wr_addr = 4'd3; a.wr_data = 16'h5555;
        #1 reset = 1'b1;
        #1;
        chk("midrst_rd1",  64'(a.rd_data1), 64'h0);
        chk("midrst_busy", 64'(a.busy_vec), 64'h0);
        chk("midrst_rdb1", 64'(a.rd_busy1), 64'h0);
        #1 reset = 1'b0;
        step();
        idle();
        #1;
        chk("release_write", 64'(a.rd_data1), 64'h5555);

        // Basic write/read on both ports, then R0 stays zero.
        a.wr_en = 1'b1; a.wr_addr = 4'd5; a.wr_data = 16'hBEEF;
        step();
        idle();
        a.rd_addr1 = 4'd5; a.rd_addr2 = 4'd5;
        #1;
        chk("r5_port1", 64'(a.rd_data1), 64'hBEEF);
        chk("r5_port2", 64'(a.rd_data2), 64'hBEEF);
        a.wr_en = 1'b1; a.wr_addr = 4'd0; a.wr_data = 16'hFFFF;
        a.rsv_en = 1'b1; a.rsv_addr = 4'd0;
        a.rd_addr1 = 4'd0;
        #1;
        chk("r0_nobypass", 64'(a.rd_data1), 64'h0);
        step();
        idle();
        #1;
        chk("r0_read",  64'(a.rd_data1), 64'h0);
        chk("r0_busy",  64'(a.busy_vec), 64'h0);

        // Both ports bypass the same in-flight write.
        a.wr_en = 1'b1; a.wr_addr = 4'd7; a.wr_data = 16'h00A5;
        a.rd_addr1 = 4'd7; a.rd_addr2 = 4'd7;
        #1;
        chk("byp_port1", 64'(a.rd_data1), 64'h00A5);
        chk("byp_port2", 64'(a.rd_data2), 64'h00A5);
        step();
        idle();

        // Reserve R4, then retire it with a bypassed write.
        a.rsv_en = 1'b1; a.rsv_addr = 4'd4;
        step();
        idle();
        a.rd_addr1 = 4'd4;
        #1;
        chk("rsv4_vec",  64'(a.busy_vec), 64'h0010);
        chk("rsv4_rdb1", 64'(a.rd_busy1), 64'h1);
        a.wr_en = 1'b1; a.wr_addr = 4'd4; a.wr_data = 16'h4444;
        #1;
        chk("wr4_rdb1_byp", 64'(a.rd_busy1), 64'h0);
        chk("wr4_rd1_byp",  64'(a.rd_data1), 64'h4444);
        step();
        idle();
        #1;
        chk("wr4_vec", 64'(a.busy_vec), 64'h0);

        // Reserve and write R6 together; the reservation wins.
        a.rsv_en = 1'b1; a.rsv_addr = 4'd6;
        a.wr_en = 1'b1; a.wr_addr = 4'd6; a.wr_data = 16'h6666;
        step();
        idle();
        a.rd_addr2 = 4'd6;
        #1;
        chk("r6_data", 64'(a.rd_data2), 64'h6666);
        chk("r6_busy", 64'(a.busy_vec), 64'h0040);
        a.rsv_en = 1'b1; a.rsv_addr = 4'd1;
        step();
        a.rsv_addr = 4'd9;
        step();
        idle();
        #1;
        chk("busy_1_6_9", 64'(a.busy_vec), 64'h0242);
        a.rsv_en = 1'b1; a.rsv_addr = 4'd2; a.flush = 1'b1;
        step();
        idle();
        #1;
        chk("rsv_flush", 64'(a.busy_vec), 64'h0004);
        // Flush leaves data alone.
        a.rd_addr1 = 4'd5;
        #1;
        chk("flush_keeps_data", 64'(a.rd_data1), 64'hBEEF);

        // Wide file, no bypass: old value visible during the write cycle.
        b.wr_en = 1'b1; b.wr_addr = 5'd31; b.wr_data = 32'hDEADBEEF;
        b.rd_addr1 = 5'd31;
        #1;
        chk("b_nobyp_old", 64'(b.rd_data1), 64'h0);
        step();
        idle();
        #1;
        chk("b_r31", 64'(b.rd_data1), 64'hDEADBEEF);
        b.rsv_en = 1'b1; b.rsv_addr = 5'd31;
        step();
        idle();
        #1;
        chk("b_busy31", 64'(b.busy_vec), 64'h8000_0000);
        b.wr_en = 1'b1; b.wr_addr = 5'd31; b.wr_data = 32'h0BADF00D;
        #1;
        chk("b_nobyp_busy", 64'(b.rd_busy1), 64'h1);
        chk("b_nobyp_data", 64'(b.rd_data1), 64'hDEADBEEF);
        step();
        idle();
        #1;
        chk("b_wr31_busy", 64'(b.rd_busy1), 64'h0);
        chk("b_wr31_data", 64'(b.rd_data1), 64'h0BADF00D);

        // R0 is ordinary when it is not hardwired.
        b.wr_en = 1'b1; b.wr_addr = 5'd0; b.wr_data = 32'hCAFEF00D;
        b.rsv_en = 1'b1; b.rsv_addr = 5'd0;
        step();
        idle();
        b.rd_addr2 = 5'd0;
        #1;
        chk("b_r0_data", 64'(b.rd_data2), 64'hCAFEF00D);
        chk("b_r0_busy", 64'(b.rd_busy2), 64'h1);
        chk("b_r0_vec",  64'(b.busy_vec), 64'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised general-purpose register file for the next CPU datapath revision: two asynchronous read ports and one synchronous write port.
- Write-to-read bypass, optional hardwired-zero R0, and a per-register busy scoreboard.
- The decode stage uses the busy flags to detect RAW hazards against in-flight producers (multi-cycle ALU ops, loads).
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
DATA_WIDTH, 16, width of each register in bits
ADDR_WIDTH, 4, register address width; register count NUM_REGS = 2**ADDR_WIDTH (derived, not overridable)
ZERO_REG, 1, 1 = R0 reads as 0 and ignores writes and reservations; 0 = R0 is an ordinary register
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all registers and busy bits
rd_addr1  input  ADDR_WIDTH  read port 1 address
rd_addr2  input  ADDR_WIDTH  read port 2 address
rd_data1  output  DATA_WIDTH  read port 1 data (combinational)
rd_data2  output  DATA_WIDTH  read port 2 data (combinational)
rd_busy1  output  1  busy flag of rd_addr1, after bypass adjustment
rd_busy2  output  1  busy flag of rd_addr2, after bypass adjustment
wr_en  input  1  write strobe
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
rsv_en  input  1  reserve destination; marks rsv_addr busy
rsv_addr  input  ADDR_WIDTH  register to mark busy
flush  input  1  synchronous clear of all busy bits (pipeline flush); register contents untouched
busy_vec  output  NUM_REGS  registered busy bits, bit i = register i

Behaviour:
- Reset (async, any time, including mid-write): all registers = 0 and all busy bits = 0 immediately. Outputs then show rd_data = 0, rd_busy = 0, busy_vec = 0. A write in the reset-release cycle is still applied on the next edge with reset low.
- Write: on posedge with wr_en = 1, regs[wr_addr] <= wr_data. Write-to-storage latency is 1 cycle.
- Read: rd_dataN = regs[rd_addrN], purely combinational.
- Bypass (BYPASS = 1): if wr_en && wr_addr == rd_addrN and the write is effective, then rd_dataN = wr_data and rd_busyN = 0 in the same cycle.
  - Both ports can bypass simultaneously.
  - With BYPASS = 0, the old value and the stored busy bit are shown until the edge.
- Effective write/reserve: with ZERO_REG = 1, address 0 is never written or reserved. rd_dataN = 0 and rd_busyN = 0 for address 0 regardless of other inputs. busy_vec[0] is constant 0.
- Busy-bit next state for register i, applied at each posedge in priority order (highest first):
  1. set if rsv_en && rsv_addr == i (effective);
  2. else clear if flush;
  3. else clear if wr_en && wr_addr == i (effective);
  4. else hold.
- Simultaneous rsv and write to the same address: the busy bit ends set (the reservation is a younger producer), and the register data is still written.
- rsv and flush in the same cycle: only the reserved register is left busy.
- Writing a register that is not busy is legal: data is updated and the busy bit stays 0.
- Reserving an already-busy register is legal: it stays busy.
- rd_busyN without bypass = busy_vec[rd_addrN].
- No width conversion: all data paths are exactly DATA_WIDTH. Address compares are full ADDR_WIDTH.

Test Plan:
- Reset mid-operation: write R3=16'h1234; assert reset asynchronously between edges -> rd_data of R3 = 0 and busy_vec = 0 before the next edge.
- Basic write/read: write R5=16'hBEEF; next cycle rd_addr1=5, rd_addr2=5 -> both read 16'hBEEF. Write R0=16'hFFFF with ZERO_REG=1 -> R0 reads 0.
- Bypass: wr_en, wr_addr=7, wr_data=16'h00A5, rd_addr1=7 in the same cycle -> rd_data1 = 16'h00A5 combinationally. Same test with BYPASS=0 -> old value, new value after the edge.
- Scoreboard: rsv R4 -> busy_vec[4]=1 and rd_busy1=1 for rd_addr1=4. Later write R4 -> rd_busy1=0 in the write cycle (bypass), busy_vec[4]=0 after the edge.
- Collisions: rsv R6 and write R6 in the same cycle -> R6 updated and busy_vec[6]=1. rsv R2 with flush while R1, R9 busy -> busy_vec has only bit 2 set.
- Parameter sweep: DATA_WIDTH=32, ADDR_WIDTH=5 -> write R31=32'hDEADBEEF reads back correctly; busy_vec width is 32.
